// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle 16-bit RISC: sequences IF/ID/EX/MEM/WB,
// decodes InsM/InsL/PSW into datapath controls, and keeps cycle/retire counters.
module multicycle_ctrl #(
   parameter int CNT_W    = 16,
   parameter bit AUTO_RUN = 1'b0
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             Run,
   input  logic [7:0]       InsM,
   input  logic [1:0]       InsL,
   input  logic [2:0]       PSW_NZC,
   output logic [1:0]       Jump,
   output logic             Branch,
   output logic             Buff_PC,
   output logic             WBresource,
   output logic             PCplus1orWB,
   output logic             RBresource,
   output logic             WE_RF,
   output logic             LI,
   output logic             oprandB,
   output logic             Flag,
   output logic             ALUop,
   output logic             Buff_PSW,
   output logic             Buff_OutR,
   output logic             MEMresource,
   output logic             LIorMOV,
   output logic             ALUorNot,
   output logic             Buff_MEMIns,
   output logic             WE_MEM,
   output logic             Halted,
   output logic             Illegal,
   output logic [2:0]       state_dbg,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_IF   = 3'd1,
      S_ID   = 3'd2,
      S_EX   = 3'd3,
      S_MEM  = 3'd4,
      S_WB   = 3'd5,
      S_HALT = 3'd6
   } state_e;

   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_MOV  = 5'b00001;
   localparam logic [4:0] OP_LI   = 5'b00010;
   localparam logic [4:0] OP_LD   = 5'b00011;
   localparam logic [4:0] OP_ST   = 5'b00100;
   localparam logic [4:0] OP_BCC  = 5'b00101;
   localparam logic [4:0] OP_JMP  = 5'b00110;
   localparam logic [4:0] OP_JAL  = 5'b00111;
   localparam logic [4:0] OP_JR   = 5'b01000;
   localparam logic [4:0] OP_HALT = 5'b11111;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
   logic [4:0]       opcode_s;
   logic [2:0]       cond_s;
   logic             flag_n_s, flag_z_s, flag_c_s;
   logic             taken_s, known_s, uses_mem_s, active_s, retire_s;

   assign opcode_s = InsM[7:3];
   assign cond_s   = InsM[2:0];
   assign flag_n_s = PSW_NZC[2];
   assign flag_z_s = PSW_NZC[1];
   assign flag_c_s = PSW_NZC[0];

   // Opcode classification and branch condition evaluation
   always_comb begin
      uses_mem_s = 1'b0;
      known_s    = 1'b1;
      case (opcode_s)
         OP_ALU, OP_MOV, OP_LI, OP_LD, OP_ST: uses_mem_s = 1'b1;
         OP_BCC, OP_JMP, OP_JAL, OP_JR, OP_HALT: uses_mem_s = 1'b0;
         default: known_s = 1'b0;
      endcase
      case (cond_s)
         3'b000:  taken_s = flag_z_s;
         3'b001:  taken_s = ~flag_z_s;
         3'b010:  taken_s = flag_c_s;
         3'b011:  taken_s = ~flag_c_s;
         3'b100:  taken_s = flag_n_s;
         3'b101:  taken_s = ~flag_n_s;
         3'b110:  taken_s = 1'b1;
         default: taken_s = 1'b0;
      endcase
   end

   // Next-state, retirement and saturating counter updates
   always_comb begin
      state_d  = state_q;
      retire_s = 1'b0;
      active_s = (state_q == S_IF) || (state_q == S_ID) || (state_q == S_EX) ||
                 (state_q == S_MEM) || (state_q == S_WB);
      case (state_q)
         S_IDLE: if (Run || AUTO_RUN) state_d = S_IF; else state_d = S_IDLE;
         S_IF:   state_d = S_ID;
         S_ID:   state_d = S_EX;
         S_EX: begin
            if (opcode_s == OP_HALT) begin
               state_d  = S_HALT;
               retire_s = 1'b1;
            end else if (uses_mem_s) begin
               state_d = S_MEM;
            end else begin
               state_d  = S_IF;
               retire_s = 1'b1;
            end
         end
         S_MEM: begin
            if (opcode_s == OP_ST) begin
               state_d  = S_IF;
               retire_s = 1'b1;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            state_d  = S_IF;
            retire_s = 1'b1;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      cycle_cnt_d  = cycle_cnt_q;
      retire_cnt_d = retire_cnt_q;
      if (active_s && (cycle_cnt_q != {CNT_W{1'b1}})) cycle_cnt_d = cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      else cycle_cnt_d = cycle_cnt_q;
      if (retire_s && (retire_cnt_q != {CNT_W{1'b1}})) retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      else retire_cnt_d = retire_cnt_q;
   end

   // State and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q      <= S_IDLE;
         cycle_cnt_q  <= {CNT_W{1'b0}};
         retire_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         cycle_cnt_q  <= cycle_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // Datapath controls; Rst forces everything low so an in-flight write is dropped
   always_comb begin
      Jump        = 2'b00;
      Branch      = 1'b0;
      Buff_PC     = 1'b0;
      WBresource  = 1'b0;
      PCplus1orWB = 1'b0;
      RBresource  = 1'b0;
      WE_RF       = 1'b0;
      LI          = 1'b0;
      oprandB     = 1'b0;
      Flag        = 1'b0;
      ALUop       = 1'b0;
      Buff_PSW    = 1'b0;
      Buff_OutR   = 1'b0;
      MEMresource = 1'b0;
      LIorMOV     = 1'b0;
      ALUorNot    = 1'b0;
      Buff_MEMIns = 1'b0;
      WE_MEM      = 1'b0;
      Illegal     = 1'b0;
      if (Rst) begin
         Jump = 2'b00;
      end else begin
         case (state_q)
            S_IF: begin
               PCplus1orWB = 1'b1;
               Buff_MEMIns = 1'b1;
               Buff_PC     = 1'b1;
            end
            S_ID: PCplus1orWB = 1'b1;
            S_EX: begin
               PCplus1orWB = 1'b1;
               case (opcode_s)
                  OP_ALU: begin
                     Buff_PSW = 1'b1;
                     Flag     = InsL[1];
                     ALUop    = InsL[0];
                  end
                  OP_MOV: Buff_OutR = 1'b1;
                  OP_LI:  LI = 1'b1;
                  OP_LD:  oprandB = 1'b1;
                  OP_ST: begin
                     oprandB    = 1'b1;
                     RBresource = 1'b1;
                  end
                  OP_BCC: begin
                     Branch  = taken_s;
                     Buff_PC = taken_s;
                  end
                  OP_JMP: begin
                     Jump    = 2'b01;
                     Buff_PC = 1'b1;
                  end
                  OP_JAL: begin
                     Jump        = 2'b10;
                     Buff_PC     = 1'b1;
                     PCplus1orWB = 1'b0;
                     WE_RF       = 1'b1;
                  end
                  OP_JR: begin
                     Jump    = 2'b11;
                     Buff_PC = 1'b1;
                  end
                  OP_HALT: Illegal = 1'b0;
                  default: Illegal = 1'b1;
               endcase
            end
            S_MEM: begin
               PCplus1orWB = 1'b1;
               case (opcode_s)
                  OP_MOV: begin
                     ALUorNot = 1'b1;
                     LIorMOV  = 1'b1;
                  end
                  OP_LI:  ALUorNot = 1'b1;
                  OP_LD:  MEMresource = 1'b1;
                  OP_ST: begin
                     MEMresource = 1'b1;
                     WE_MEM      = 1'b1;
                  end
                  default: ALUorNot = 1'b0;
               endcase
            end
            S_WB: begin
               PCplus1orWB = 1'b1;
               WE_RF       = 1'b1;
               WBresource  = (opcode_s == OP_LD);
            end
            default: Jump = 2'b00;
         endcase
      end
   end

   assign Halted     = (state_q == S_HALT);
   assign state_dbg  = state_q;
   assign cycle_cnt  = cycle_cnt_q;
   assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of instructions with per-state expected
// control words queued in a scoreboard, plus reset/HALT corner sequences.
module tb_multicycle_ctrl;

   typedef logic [19:0] ctrl_t;
   localparam ctrl_t K_J01  = 20'h40000;
   localparam ctrl_t K_J10  = 20'h80000;
   localparam ctrl_t K_J11  = 20'hC0000;
   localparam ctrl_t K_BR   = 20'h20000;
   localparam ctrl_t K_BPC  = 20'h10000;
   localparam ctrl_t K_WBR  = 20'h08000;
   localparam ctrl_t K_P1   = 20'h04000;
   localparam ctrl_t K_RBR  = 20'h02000;
   localparam ctrl_t K_WERF = 20'h01000;
   localparam ctrl_t K_LI   = 20'h00800;
   localparam ctrl_t K_OPB  = 20'h00400;
   localparam ctrl_t K_FLAG = 20'h00200;
   localparam ctrl_t K_AOP  = 20'h00100;
   localparam ctrl_t K_PSW  = 20'h00080;
   localparam ctrl_t K_OUTR = 20'h00040;
   localparam ctrl_t K_MEMR = 20'h00020;
   localparam ctrl_t K_LMOV = 20'h00010;
   localparam ctrl_t K_ALUN = 20'h00008;
   localparam ctrl_t K_MINS = 20'h00004;
   localparam ctrl_t K_WEM  = 20'h00002;
   localparam ctrl_t K_ILL  = 20'h00001;
   localparam ctrl_t K_IF   = K_P1 | K_MINS | K_BPC;

   typedef struct {
      logic [7:0] insm;
      logic [1:0] insl;
      logic [2:0] psw;
      int         len;
      ctrl_t      ex, mem, wb;
   } vec_t;

   typedef struct {
      logic [2:0] st;
      ctrl_t      c;
   } exp_t;

   logic clk = 1'b0, Rst, Run;
   logic [7:0] InsM;
   logic [1:0] InsL;
   logic [2:0] PSW_NZC;
   logic [1:0] Jump;
   logic Branch, Buff_PC, WBresource, PCplus1orWB, RBresource, WE_RF, LI, oprandB;
   logic Flag, ALUop, Buff_PSW, Buff_OutR, MEMresource, LIorMOV, ALUorNot;
   logic Buff_MEMIns, WE_MEM, Halted, Illegal;
   logic [2:0]  state_dbg;
   logic [15:0] cycle_cnt, retire_cnt;
   ctrl_t got_c;

   int n_cmp = 0, n_fail = 0;
   int exp_cyc = 0, exp_ret = 0;
   vec_t vecs[$];
   exp_t sb[$];

   multicycle_ctrl #(.CNT_W(16), .AUTO_RUN(1'b0)) dut (
      .clk(clk), .Rst(Rst), .Run(Run), .InsM(InsM), .InsL(InsL), .PSW_NZC(PSW_NZC),
      .Jump(Jump), .Branch(Branch), .Buff_PC(Buff_PC), .WBresource(WBresource),
      .PCplus1orWB(PCplus1orWB), .RBresource(RBresource), .WE_RF(WE_RF), .LI(LI),
      .oprandB(oprandB), .Flag(Flag), .ALUop(ALUop), .Buff_PSW(Buff_PSW),
      .Buff_OutR(Buff_OutR), .MEMresource(MEMresource), .LIorMOV(LIorMOV),
      .ALUorNot(ALUorNot), .Buff_MEMIns(Buff_MEMIns), .WE_MEM(WE_MEM),
      .Halted(Halted), .Illegal(Illegal), .state_dbg(state_dbg),
      .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
   );

   assign got_c = {Jump, Branch, Buff_PC, WBresource, PCplus1orWB, RBresource, WE_RF, LI,
                   oprandB, Flag, ALUop, Buff_PSW, Buff_OutR, MEMresource, LIorMOV,
                   ALUorNot, Buff_MEMIns, WE_MEM, Illegal};

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic add(input logic [7:0] m, input logic [1:0] l, input logic [2:0] p,
                      input int len, input ctrl_t ex, input ctrl_t mem, input ctrl_t wb);
      vec_t v;
      v.insm = m; v.insl = l; v.psw = p; v.len = len;
      v.ex = ex; v.mem = mem; v.wb = wb;
      vecs.push_back(v);
   endtask

   task automatic check_counters(input string tag);
      check({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'(exp_cyc));
      check({tag, " retire_cnt"}, 64'(retire_cnt), 64'(exp_ret));
   endtask

   // Entered at the negedge of an IF cycle; leaves at the negedge after the last state
   task automatic run_vec(input vec_t v, input string tag);
      exp_t e;
      InsM = v.insm; InsL = v.insl; PSW_NZC = v.psw;
      sb.push_back('{3'd1, K_IF});
      sb.push_back('{3'd2, K_P1});
      sb.push_back('{3'd3, v.ex});
      if (v.len >= 4) sb.push_back('{3'd4, v.mem});
      if (v.len == 5) sb.push_back('{3'd5, v.wb});
      exp_cyc += v.len;
      exp_ret += 1;
      for (int k = 0; k < v.len; k++) begin
         #1;
         if (sb.size() == 0) begin
            check({tag, " sb_underflow"}, 64'(k), 64'(v.len));
         end else begin
            e = sb.pop_front();
            check($sformatf("%s c%0d state", tag, k), 64'(state_dbg), 64'(e.st));
            check($sformatf("%s c%0d ctrl", tag, k), 64'(got_c), 64'(e.c));
         end
         step();
      end
      #1;
      check({tag, " sb_empty"}, 64'(sb.size()), 64'd0);
      check_counters(tag);
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      step();
      step();
      Rst = 1'b0;
      exp_cyc = 0;
      exp_ret = 0;
   endtask

   initial begin
      vec_t li_v, add_v, halt_v, st_v;
      Rst = 1'b1; Run = 1'b0; InsM = 8'h00; InsL = 2'b00; PSW_NZC = 3'b000;

      // ALU ops, data moves and memory ops
      add(8'b00000_011, 2'b00, 3'b000, 5, K_P1 | K_PSW, K_P1, K_P1 | K_WERF);
      add(8'b00000_011, 2'b01, 3'b000, 5, K_P1 | K_PSW | K_AOP, K_P1, K_P1 | K_WERF);
      add(8'b00000_011, 2'b10, 3'b000, 5, K_P1 | K_PSW | K_FLAG, K_P1, K_P1 | K_WERF);
      add(8'b00000_011, 2'b11, 3'b000, 5, K_P1 | K_PSW | K_FLAG | K_AOP, K_P1, K_P1 | K_WERF);
      add(8'b00001_001, 2'b00, 3'b000, 5, K_P1 | K_OUTR, K_P1 | K_ALUN | K_LMOV, K_P1 | K_WERF);
      add(8'b00010_001, 2'b00, 3'b000, 5, K_P1 | K_LI, K_P1 | K_ALUN, K_P1 | K_WERF);
      add(8'b00011_100, 2'b00, 3'b000, 5, K_P1 | K_OPB, K_P1 | K_MEMR, K_P1 | K_WERF | K_WBR);
      add(8'b00100_001, 2'b00, 3'b000, 4, K_P1 | K_OPB | K_RBR, K_P1 | K_MEMR | K_WEM, 20'h0);
      // Branches across all conditions, taken and not taken
      add(8'b00101_000, 2'b00, 3'b010, 3, K_P1 | K_BR | K_BPC, 20'h0, 20'h0);
      add(8'b00101_000, 2'b00, 3'b000, 3, K_P1, 20'h0, 20'h0);
      add(8'b00101_001, 2'b00, 3'b010, 3, K_P1, 20'h0, 20'h0);
      add(8'b00101_001, 2'b00, 3'b000, 3, K_P1 | K_BR | K_BPC, 20'h0, 20'h0);
      add(8'b00101_010, 2'b00, 3'b001, 3, K_P1 | K_BR | K_BPC, 20'h0, 20'h0);
      add(8'b00101_011, 2'b00, 3'b001, 3, K_P1, 20'h0, 20'h0);
      add(8'b00101_100, 2'b00, 3'b100, 3, K_P1 | K_BR | K_BPC, 20'h0, 20'h0);
      add(8'b00101_101, 2'b00, 3'b100, 3, K_P1, 20'h0, 20'h0);
      add(8'b00101_110, 2'b00, 3'b000, 3, K_P1 | K_BR | K_BPC, 20'h0, 20'h0);
      add(8'b00101_111, 2'b00, 3'b111, 3, K_P1, 20'h0, 20'h0);
      // Jumps and undefined opcodes
      add(8'b00110_000, 2'b00, 3'b000, 3, K_P1 | K_BPC | K_J01, 20'h0, 20'h0);
      add(8'b00111_000, 2'b00, 3'b000, 3, K_BPC | K_J10 | K_WERF, 20'h0, 20'h0);
      add(8'b01000_000, 2'b00, 3'b000, 3, K_P1 | K_BPC | K_J11, 20'h0, 20'h0);
      add(8'b10101_000, 2'b00, 3'b000, 3, K_P1 | K_ILL, 20'h0, 20'h0);
      add(8'b01001_010, 2'b00, 3'b000, 3, K_P1 | K_ILL, 20'h0, 20'h0);

      // Reset state, then IDLE holds while Run is low
      step();
      step();
      #1;
      check("rst state", 64'(state_dbg), 64'd0);
      check("rst ctrl", 64'(got_c), 64'd0);
      check("rst cycle_cnt", 64'(cycle_cnt), 64'd0);
      check("rst retire_cnt", 64'(retire_cnt), 64'd0);
      check("rst halted", 64'(Halted), 64'd0);
      Rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         check("idle state", 64'(state_dbg), 64'd0);
         check("idle ctrl", 64'(got_c), 64'd0);
      end

      // Program LI, LI, ADD, HALT: 18 counted cycles, 4 retirements
      Run = 1'b1;
      step();
      li_v  = vecs[5];
      add_v = vecs[0];
      halt_v.insm = 8'b11111_000; halt_v.insl = 2'b00; halt_v.psw = 3'b000; halt_v.len = 3;
      halt_v.ex = K_P1; halt_v.mem = 20'h0; halt_v.wb = 20'h0;
      run_vec(li_v, "prog_li1");
      run_vec(li_v, "prog_li2");
      run_vec(add_v, "prog_add");
      run_vec(halt_v, "prog_halt");
      check("prog cycle_cnt 18", 64'(cycle_cnt), 64'd18);
      check("prog retire_cnt 4", 64'(retire_cnt), 64'd4);
      check("halt state", 64'(state_dbg), 64'd6);
      check("halt halted", 64'(Halted), 64'd1);
      check("halt ctrl", 64'(got_c), 64'd0);
      Run = 1'b0;
      step();
      Run = 1'b1;
      step();
      step();
      #1;
      check("halt absorbing", 64'(state_dbg), 64'd6);
      check("halt counters frozen", 64'({cycle_cnt, retire_cnt}), 64'({16'd18, 16'd4}));

      // Full instruction table from a fresh reset
      do_reset();
      #1;
      check("rst2 state", 64'(state_dbg), 64'd0);
      check("rst2 halted", 64'(Halted), 64'd0);
      step();
      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset landing in the MEM cycle of a store suppresses WE_MEM
      st_v = vecs[7];
      InsM = st_v.insm; InsL = st_v.insl; PSW_NZC = st_v.psw;
      step();
      step();
      step();
      #1;
      check("st mem state", 64'(state_dbg), 64'd4);
      check("st mem ctrl", 64'(got_c), 64'(K_P1 | K_MEMR | K_WEM));
      Rst = 1'b1;
      Run = 1'b0;
      #1;
      check("st rst we_mem", 64'(WE_MEM), 64'd0);
      check("st rst ctrl", 64'(got_c), 64'd0);
      step();
      Rst = 1'b0;
      #1;
      check("st rst state", 64'(state_dbg), 64'd0);
      check("st rst cycle_cnt", 64'(cycle_cnt), 64'd0);
      check("st rst retire_cnt", 64'(retire_cnt), 64'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         #1;
         check("post rst idle state", 64'(state_dbg), 64'd0);
         check("post rst idle ctrl", 64'(got_c), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control unit for the simplified multicycle 16-bit RISC processor.
- Sequences the datapath through IF/ID/EX/MEM/WB one state per clock, from the latched instruction byte InsM, the function bits InsL and the PSW flags.
- Drives every datapath control input; counts cycles and retired instructions for bench checks.
- Holds in IDLE while the testbench preloads memory.

Parameters:
- CNT_W, 16, width of cycle_cnt and retire_cnt (saturating).
- AUTO_RUN, 0, when 1 leave IDLE on the first clock after reset without waiting for Run.

Ports:
- clk  in  1  rising-edge clock
- Rst  in  1  synchronous active-high reset
- Run  in  1  level; allows IDLE->IF, sampled only in IDLE
- InsM  in  8  instruction buffer bits [15:8]; opcode = InsM[7:3], cond = InsM[2:0]
- InsL  in  2  instruction buffer bits [1:0]; ALU function
- PSW_NZC  in  3  {N,Z,C} from PSW register
- Jump  out  2  00 PC+1/branch, 01 absolute, 10 link-jump, 11 register
- Branch, Buff_PC  out  1 each  PC control
- WBresource, PCplus1orWB, RBresource, WE_RF, LI, oprandB, Flag, ALUop, Buff_PSW, Buff_OutR  out  1 each  RF/ALU control
- MEMresource, LIorMOV, ALUorNot, Buff_MEMIns, WE_MEM  out  1 each  memory control
- Halted  out  1  high in HALT
- Illegal  out  1  one-cycle pulse on an undefined opcode
- state_dbg  out  3  encoded state
- cycle_cnt, retire_cnt  out  CNT_W each  counters

Behaviour:
- Reset (sync, Rst=1 at posedge): state=IDLE, counters=0, Illegal=0. Reset has priority and aborts any instruction mid-flight, including a pending WE_MEM/WE_RF.
- Control outputs are combinational from (state, InsM, InsL, PSW_NZC).
- Default value of every control output is 0, except PCplus1orWB=1. All controls are 0 in IDLE, HALT and reset.
- States and encodings: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6.
- IDLE -> IF when Run=1 or AUTO_RUN=1.
- IF: MEMresource=0, Buff_MEMIns=1, Buff_PC=1 (PC<=PC+1). Next state ID.
- ID: register read, no enables. Next state EX.
- Opcodes:
  - 00000 ALU: function by InsL. 00 ADD (ALUop=0, Flag=0); 01 SUB (ALUop=1, Flag=0); 10 ADC (ALUop=0, Flag=1); 11 SBB (ALUop=1, Flag=1). EX: oprandB=0, Buff_PSW=1. MEM: ALUorNot=0. WB: WE_RF=1, WBresource=0. Total 5 cycles.
  - 00001 MOV: EX: Buff_OutR=1. MEM: ALUorNot=1, LIorMOV=1. WB: WE_RF=1. Total 5 cycles.
  - 00010 LI: EX: LI=1. MEM: ALUorNot=1, LIorMOV=0. WB: WE_RF=1. Total 5 cycles.
  - 00011 LD: EX: oprandB=1 (base+imm), ALUop=0. MEM: MEMresource=1. WB: WE_RF=1, WBresource=1. Total 5 cycles.
  - 00100 ST: EX: oprandB=1, RBresource=1. MEM: MEMresource=1, WE_MEM=1, then IF. Total 4 cycles.
  - 00101 Bcc: EX evaluates cond. 000 Z; 001 !Z; 010 C; 011 !C; 100 N; 101 !N; 110 always; 111 never. If taken: Branch=1, Buff_PC=1. Then IF either way. Total 3 cycles.
  - 00110 JMP: EX: Jump=01, Buff_PC=1. Total 3 cycles.
  - 00111 JAL: EX: Jump=10, Buff_PC=1, PCplus1orWB=0, WE_RF=1. Total 3 cycles.
  - 01000 JR: EX: Jump=11, Buff_PC=1. Total 3 cycles.
  - 11111 HALT: EX -> HALT. HALT is absorbing until Rst; Run is ignored there.
  - Any other opcode: Illegal=1 during EX, no writes, -> IF. Treated as a 3-cycle NOP.
- The condition uses PSW_NZC as held in EX. A Bcc directly after an ALU op sees that op's flags, because Buff_PSW is written at the end of the ALU EX, long before the next Bcc EX.
- cycle_cnt: +1 every clock in states IF..WB. It does not count in IDLE or HALT, and saturates at all-ones.
- retire_cnt: +1 on the final state of each instruction (WB, MEM for ST, EX for branch/jump/illegal). HALT counts once on entering HALT. Saturates.

Test Plan:
- Memory = LI r1,5; LI r2,3; ADD r3,r1,r2; HALT; Run=1 -> r3=8, PSW=000, Halted=1, retire_cnt=4, cycle_cnt=5+5+5+3=18.
- SUB r3,r1,r1 then BEQ +2 (cond 000) -> Z=1, Branch=1 for one EX cycle, PC=branch target. Repeat with BNE -> not taken, PC = Bcc address+1, Branch never asserted.
- ST r1,[r0+0x20] then LD r4,[r0+0x20] -> WE_MEM high exactly one cycle (MEM state, MEMresource=1), r4=5, ST takes 4 cycles and LD takes 5.
- JAL at address 0x10 -> PCplus1orWB=0 and WE_RF=1 in the same EX cycle, link register=0x11, next fetch from target.
- Opcode 10101 -> Illegal pulse exactly 1 cycle, no WE_RF/WE_MEM, execution continues at the next address.
- Rst asserted in MEM of a ST -> WE_MEM=0 that cycle, state=IDLE, counters=0. Hold Run=0 -> stays IDLE with all controls 0.
